// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave datapath: FSM encoding, mode helper
// and the default widths used by the byte receiver and the pulse counter.
`timescale 1ns/1ps

package spi_slave_pkg;

  localparam int unsigned STATE_SIZE            = 2;
  localparam int unsigned DEFAULT_DATAWIDTH_BUS = 8;
  localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
  localparam logic        DEFAULT_CPOL          = 1'b0;
  localparam logic        DEFAULT_CPHA          = 1'b0;

  typedef enum logic [STATE_SIZE-1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd2,
    NOTIFY = 2'd3
  } rx_state_e;

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_rising(input logic cpol, input logic cpha);
    return (cpol ^ cpha) == 1'b0;
  endfunction

  localparam logic SAMPLE_RISING = sample_rising(DEFAULT_CPOL, DEFAULT_CPHA);

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, followed by a registered
// edge detector producing single-cycle rise/fall strobes.
`timescale 1ns/1ps

module spi_sync_edge #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Reset to the pin's idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_LEVEL}};
      prev_q <= RESET_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the value from
      // before the edge; blocking ones would collapse the chain into one flop.
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave_byte_receiver.sv
// SPI slave front end: synchronises SCLK/MOSI/SS, shifts MOSI in MSB-first and
// emits count / new-data pulses for every completed byte.
`timescale 1ns/1ps

module spi_slave_byte_receiver
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = DEFAULT_DATAWIDTH_BUS,
  parameter logic        CPOL          = DEFAULT_CPOL,
  parameter logic        CPHA          = DEFAULT_CPHA,
  parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic                               PULSE_COUNTER_CLOCK_50,
  input  logic                               PULSE_COUNTER_RESET_InHigh,
  input  logic                               SPI_SCLK_In,
  input  logic                               SPI_MOSI_In,
  input  logic                               SPI_SS_InLow,
  output logic [DATAWIDTH_BUS-1:0]           RX_data_Out,
  output logic                               RX_count_OutHigh,
  output logic                               RX_newData_OutHigh,
  output logic [$clog2(DATAWIDTH_BUS):0]     RX_bitCount_Out,
  output logic                               RX_frameError_OutHigh
);

  localparam int unsigned CNT_W              = $clog2(DATAWIDTH_BUS) + 1;
  localparam logic        SAMPLE_EDGE_RISING = sample_rising(CPOL, CPHA);
  localparam logic [CNT_W-1:0] LAST_BIT      = CNT_W'(DATAWIDTH_BUS - 1);

  logic clk;
  logic rst;
  assign clk = PULSE_COUNTER_CLOCK_50;
  assign rst = PULSE_COUNTER_RESET_InHigh;

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic sample_edge;
  logic mosi_bit;

  spi_sync_edge #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (CPOL)
  ) u_sclk_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .pin_i   (SPI_SCLK_In),
    .level_o (sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (1'b1)
  ) u_ss_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .pin_i   (SPI_SS_InLow),
    .level_o (ss_level),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  // MOSI gets the same synchroniser depth so it stays aligned to SCLK.
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI_In};
    end
  end

  assign mosi_bit = mosi_sync_q[SYNC_STAGES-1];

  // Qualifying the strobe with the current level rejects one-clock SCLK glitches.
  assign sample_edge = SAMPLE_EDGE_RISING ? (sclk_rise &  sclk_level)
                                          : (sclk_fall & ~sclk_level);

  rx_state_e                state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] shift_q, shift_d;
  logic [DATAWIDTH_BUS-1:0] data_q,  data_d;
  logic [CNT_W-1:0]         cnt_q,   cnt_d;
  logic                     err_q,   err_d;
  logic                     count_q, count_d;
  logic                     new_q,   new_d;

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (cnt_q != '0) begin
            err_d = 1'b1;
          end
        end else if (sample_edge) begin
          shift_d = {shift_q[DATAWIDTH_BUS-2:0], mosi_bit};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
            data_d  = shift_d;
          end
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = NOTIFY;
        if (sample_edge) begin
          err_d = 1'b1;
        end
      end

      NOTIFY: begin
        state_d = ss_level ? IDLE : SHIFT;
        if (sample_edge) begin
          err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Pulses are registered from the next state so they line up with DONE/NOTIFY.
    count_d = (state_d == DONE);
    new_d   = (state_d == NOTIFY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      count_q <= 1'b0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      count_q <= count_d;
      new_q   <= new_d;
    end
  end

  assign RX_data_Out           = data_q;
  assign RX_count_OutHigh      = count_q;
  assign RX_newData_OutHigh    = new_q;
  assign RX_bitCount_Out       = cnt_q;
  assign RX_frameError_OutHigh = err_q;

endmodule

// File: tb/tb_spi_slave_byte_receiver.sv
// Self-checking bench: a mode-0 and a mode-3 receiver, each fed SPI frames,
// with a per-mode scoreboard of expected bytes checked on every count pulse.
`timescale 1ns/1ps

module tb_spi_slave_byte_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic       sclk    [2];
  logic       mosi    [2];
  logic       ss_n    [2];
  logic [7:0] rx_data [2];
  logic       rx_count[2];
  logic       rx_new  [2];
  logic [3:0] rx_bits [2];
  logic       rx_err  [2];

  spi_slave_byte_receiver #(
    .DATAWIDTH_BUS(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)
  ) dut_m0 (
    .PULSE_COUNTER_CLOCK_50     (clk),
    .PULSE_COUNTER_RESET_InHigh (rst),
    .SPI_SCLK_In                (sclk[0]),
    .SPI_MOSI_In                (mosi[0]),
    .SPI_SS_InLow               (ss_n[0]),
    .RX_data_Out                (rx_data[0]),
    .RX_count_OutHigh           (rx_count[0]),
    .RX_newData_OutHigh         (rx_new[0]),
    .RX_bitCount_Out            (rx_bits[0]),
    .RX_frameError_OutHigh      (rx_err[0])
  );

  spi_slave_byte_receiver #(
    .DATAWIDTH_BUS(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)
  ) dut_m3 (
    .PULSE_COUNTER_CLOCK_50     (clk),
    .PULSE_COUNTER_RESET_InHigh (rst),
    .SPI_SCLK_In                (sclk[1]),
    .SPI_MOSI_In                (mosi[1]),
    .SPI_SS_InLow               (ss_n[1]),
    .RX_data_Out                (rx_data[1]),
    .RX_count_OutHigh           (rx_count[1]),
    .RX_newData_OutHigh         (rx_new[1]),
    .RX_bitCount_Out            (rx_bits[1]),
    .RX_frameError_OutHigh      (rx_err[1])
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         exp_new[2];
  int         pulses [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int m, input logic [7:0] b);
    if (m == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  // Shift nbits of value MSB-first; data changes while SCLK is low, sampled on rise.
  task automatic send_bits(input int m, input logic [7:0] value, input int nbits, input int half_ns);
    for (int i = 0; i < nbits; i++) begin
      sclk[m] = 1'b0;
      mosi[m] = value[7-i];
      #(half_ns);
      sclk[m] = 1'b1;
      #(half_ns);
    end
    if (m == 0) sclk[m] = 1'b0;
  endtask

  task automatic start_frame(input int m);
    ss_n[m] = 1'b0;
    #200;
  endtask

  task automatic end_frame(input int m);
    #200;
    ss_n[m] = 1'b1;
    #200;
  endtask

  task automatic mon(input int m);
    logic [7:0] exp_b;
    bit         have;
    have  = 1'b0;
    exp_b = '0;
    if (exp_new[m] || rx_new[m])
      check($sformatf("newData_m%0d", m), rx_new[m], exp_new[m]);
    exp_new[m] = 1'b0;
    if (rx_count[m]) begin
      pulses[m]++;
      if (m == 0 && q0.size() > 0) begin exp_b = q0.pop_front(); have = 1'b1; end
      if (m == 1 && q1.size() > 0) begin exp_b = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        check($sformatf("count_unexpected_m%0d", m), rx_count[m], 0);
      end else begin
        check($sformatf("data_at_count_m%0d", m), rx_data[m], exp_b);
        exp_new[m] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_new[0] = 1'b0;
      exp_new[1] = 1'b0;
    end else begin
      mon(0);
      mon(1);
    end
  end

  task automatic check_all_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s_data_m%0d",  tag, m), rx_data[m],  0);
      check($sformatf("%s_count_m%0d", tag, m), rx_count[m], 0);
      check($sformatf("%s_new_m%0d",   tag, m), rx_new[m],   0);
      check($sformatf("%s_bits_m%0d",  tag, m), rx_bits[m],  0);
      check($sformatf("%s_err_m%0d",   tag, m), rx_err[m],   0);
    end
  endtask

  initial begin
    int p0;
    sclk[0] = 1'b0; sclk[1] = 1'b1;
    mosi[0] = 1'b0; mosi[1] = 1'b0;
    ss_n[0] = 1'b1; ss_n[1] = 1'b1;
    pulses[0] = 0;  pulses[1] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Mode 0, single byte at 5 MHz.
    push(0, 8'hA5);
    start_frame(0);
    send_bits(0, 8'hA5, 8, 100);
    end_frame(0);
    check("m0_A5_data", rx_data[0], 8'hA5);
    check("m0_A5_err", rx_err[0], 0);
    check("m0_A5_pulses", pulses[0], 1);

    // Mode 3, single byte.
    push(1, 8'h81);
    start_frame(1);
    send_bits(1, 8'h81, 8, 100);
    end_frame(1);
    check("m3_81_data", rx_data[1], 8'h81);
    check("m3_81_err", rx_err[1], 0);
    check("m3_81_pulses", pulses[1], 1);

    // Back-to-back bytes in one frame.
    p0 = pulses[0];
    push(0, 8'h3C);
    push(0, 8'hC3);
    start_frame(0);
    send_bits(0, 8'h3C, 8, 100);
    send_bits(0, 8'hC3, 8, 100);
    end_frame(0);
    check("b2b_pulse_count", pulses[0] - p0, 2);
    check("b2b_last_data", rx_data[0], 8'hC3);
    check("b2b_err", rx_err[0], 0);

    // Abort after 5 bits, with the last completed byte 0x3C.
    p0 = pulses[0];
    push(0, 8'h3C);
    start_frame(0);
    send_bits(0, 8'h3C, 8, 100);
    send_bits(0, 8'hFF, 5, 100);
    check("abort_bits_before_rise", rx_bits[0], 5);
    end_frame(0);
    check("abort_pulse_count", pulses[0] - p0, 1);
    check("abort_data_held", rx_data[0], 8'h3C);
    check("abort_err_set", rx_err[0], 1);
    ss_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_err_cleared", rx_err[0], 0);
    check("abort_bits_new_frame", rx_bits[0], 0);
    ss_n[0] = 1'b1;
    repeat (10) @(negedge clk);

    // Reset mid-byte, then a full frame.
    start_frame(0);
    send_bits(0, 8'hF0, 4, 100);
    check("pre_reset_bits", rx_bits[0], 4);
    #7;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    ss_n[0] = 1'b1;
    sclk[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    p0 = pulses[0];
    push(0, 8'h5A);
    start_frame(0);
    send_bits(0, 8'h5A, 8, 100);
    end_frame(0);
    check("post_reset_data", rx_data[0], 8'h5A);
    check("post_reset_pulses", pulses[0] - p0, 1);

    // Fast SCLK while SS is high must be ignored.
    p0 = pulses[0];
    for (int i = 0; i < 20; i++) begin
      sclk[0] = ~sclk[0];
      mosi[0] = 1'($urandom_range(1));
      #50;
      if (i == 10) check("ss_high_bits_mid", rx_bits[0], 0);
    end
    sclk[0] = 1'b0;
    #200;
    check("ss_high_bits", rx_bits[0], 0);
    check("ss_high_pulses", pulses[0] - p0, 0);
    check("ss_high_err", rx_err[0], 0);
    check("ss_high_data", rx_data[0], 8'h5A);

    repeat (10) @(negedge clk);
    check("scoreboard_m0_empty", q0.size(), 0);
    check("scoreboard_m3_empty", q1.size(), 0);
    check("total_pulses_m0", pulses[0], 5);
    check("total_pulses_m3", pulses[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_byte_receiver.md
# spi_slave_byte_receiver

Front end of the SPI slave datapath, directly upstream of the pulse counter. It synchronises the asynchronous SPI pins (SCLK, MOSI, SS) into the 50 MHz domain and detects the configured sampling edge. It shifts MOSI in MSB-first and assembles bytes. For each completed byte it emits the count pulse and the new-data pulse that drive the pulse counter's COUNT and slaveNewData inputs.

## Interface
- DATAWIDTH_BUS, 8: bits per word; sets the shift register width and the terminal bit count.
- CPOL, 0: SCLK idle level.
- CPHA, 0: sampling phase. The sampling edge is rising when CPOL^CPHA==0 and falling otherwise.
- SYNC_STAGES, 2: flip-flop depth of each pin synchroniser; minimum 2.

Ports:
- PULSE_COUNTER_CLOCK_50  in  1  system clock, 50 MHz.
- PULSE_COUNTER_RESET_InHigh  in  1  reset, asynchronous, active-high.
- SPI_SCLK_In  in  1  SPI clock pin, asynchronous.
- SPI_MOSI_In  in  1  SPI data pin, asynchronous.
- SPI_SS_InLow  in  1  slave select pin, asynchronous, active-low.
- RX_data_Out  out  DATAWIDTH_BUS  last completed byte.
- RX_count_OutHigh  out  1  one-cycle pulse per completed byte; feeds the pulse counter COUNT input.
- RX_newData_OutHigh  out  1  one-cycle pulse, exactly one clock after RX_count_OutHigh; feeds slaveNewData.
- RX_bitCount_Out  out  $clog2(DATAWIDTH_BUS)+1  bits received in the current byte.
- RX_frameError_OutHigh  out  1  sticky flag for an aborted byte or an overrun.

## Operation
- Reset values: RX_data_Out=0, RX_count_OutHigh=0, RX_newData_OutHigh=0, RX_bitCount_Out=0, RX_frameError_OutHigh=0, shift register=0, state=IDLE.
- SCLK, MOSI and SS each pass through SYNC_STAGES flip-flops of equal depth, so MOSI stays aligned to SCLK.
- One registered edge detector per synchronised SCLK and SS gives single-cycle strobes: sample_edge, ss_fall, ss_rise.
- IDLE: wait for SS low. On ss_fall, go to SHIFT, clear the bit counter and clear RX_frameError_OutHigh.
- SHIFT, on sample_edge: shift register <= {shift[W-2:0], mosi_sync}; bit counter increments.
  - When the counter reaches DATAWIDTH_BUS-1 and another sample_edge arrives, that final bit is shifted in and the state goes to DONE.
- DONE (1 cycle): RX_data_Out <= shift register; RX_count_OutHigh=1; bit counter <= 0; next state NOTIFY.
- NOTIFY (1 cycle): RX_newData_OutHigh=1; next state SHIFT, or IDLE if SS is high.
- ss_rise in SHIFT with bit counter ≠ 0: discard the partial byte, leave RX_data_Out unchanged, set RX_frameError_OutHigh=1, go to IDLE. With bit counter = 0, return to IDLE silently.
- sample_edge during DONE or NOTIFY is an overrun: the bit is dropped, RX_frameError_OutHigh=1, and the FSM continues normally.
- Any SCLK activity while SS is high is ignored.
- Bit counter width: $clog2(DATAWIDTH_BUS)+1, so the full count never wraps.

## Timing
- Pin edge to internal sample_edge: SYNC_STAGES+1 clocks (3 at the default).
- Final sample_edge in cycle N gives DONE and RX_count_OutHigh in N+1, RX_newData_OutHigh in N+2, and SHIFT ready in N+3.
- RX_data_Out is valid from N+1 and holds until the next DONE.
- RX_count_OutHigh and RX_newData_OutHigh are never high in the same cycle, which matches the pulse counter's LOAD→COUNT→IDLE sequence.
- Supported SCLK is ≤ 6.25 MHz (≥ 4 system clocks per SCLK half-period). Faster SCLK is unsupported; overruns are flagged.
- SS high time between frames: ≥ SYNC_STAGES+2 clocks.
- Reset mid-byte returns every register to its reset value immediately (asynchronous). The first byte after reset needs a fresh ss_fall.

## Structure
- Shared package spi_slave_pkg: state encodings IDLE/SHIFT/DONE/NOTIFY (2-bit), and the mode helper constant SAMPLE_RISING = (CPOL^CPHA)==0. The pulse counter uses the same package for its STATE_SIZE and DATAWIDTH_BUS defaults.
- One sub-module, spi_sync_edge: an N-stage synchroniser plus rise/fall strobes. It is instantiated for SCLK and SS; MOSI uses the synchroniser only.

## Test plan
- Mode 0, SS low, byte 0xA5 at 5 MHz: RX_data_Out=0xA5, one RX_count_OutHigh pulse, RX_newData_OutHigh exactly one clock later, RX_frameError_OutHigh=0.
- Mode 3 (CPOL=1, CPHA=1), byte 0x81: sampled on rising edges, RX_data_Out=0x81.
- Back-to-back 0x3C then 0xC3 in one SS frame: two count/newData pulse pairs, with RX_data_Out 0x3C then 0xC3. A downstream pulse counter reads 2.
- SS rises after 5 bits of 0xFF, with RX_data_Out previously 0x3C: no count pulse, RX_data_Out stays 0x3C, RX_frameError_OutHigh=1, and the flag clears on the next ss_fall.
- Reset asserted after 4 bits, then a full 0x5A frame: all outputs 0 during reset, then RX_data_Out=0x5A with exactly one pulse pair.
- SCLK toggled 10 MHz while SS high: no state change, no pulses, RX_bitCount_Out stays 0.
